// File: rtl/inst_fetch_capture_if.sv
// Fetch-bus and record-stream bundle for inst_fetch_capture; slave = capture engine.
// out_ts exists only when INST_FETCH_CAPTURE_TIMESTAMP_EN is defined.
interface inst_fetch_capture_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              enable;
  logic [ADDR_W-1:0] PC;
  logic              instrmem_rd;
  logic [DATA_W-1:0] instr_dout;
  logic              complete_instr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [3:0]        out_opcode;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
  logic [31:0]       out_ts;

  modport master (
    output enable, PC, instrmem_rd, instr_dout, complete_instr, out_ready,
    input  out_valid, out_pc, out_instr, out_opcode, out_ts
  );
  modport slave (
    input  enable, PC, instrmem_rd, instr_dout, complete_instr, out_ready,
    output out_valid, out_pc, out_instr, out_opcode, out_ts
  );
`else
  modport master (
    output enable, PC, instrmem_rd, instr_dout, complete_instr, out_ready,
    input  out_valid, out_pc, out_instr, out_opcode
  );
  modport slave (
    input  enable, PC, instrmem_rd, instr_dout, complete_instr, out_ready,
    output out_valid, out_pc, out_instr, out_opcode
  );
`endif
endinterface

// File: rtl/inst_fetch_capture.sv
// LC3 fetch capture: qualified fetches enter a DEPTH-entry {PC,instr} FIFO, head valid 1 cycle later;
// out_ready low holds the head, a full FIFO without a pop drops. Timestamps: INST_FETCH_CAPTURE_TIMESTAMP_EN.
module inst_fetch_capture #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int CAPTURE_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  inst_fetch_capture_if.slave      bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic [CNT_W-1:0]         fetch_cnt,
  output logic [CNT_W-1:0]         complete_cnt,
  output logic [CNT_W-1:0]         overflow_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
  } rec_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  rec_t              mem_q [DEPTH];
  rec_t              mem_d [DEPTH];
  logic              last_rd_q, last_rd_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  complete_cnt_q, complete_cnt_d;
  logic [CNT_W-1:0]  overflow_cnt_q, overflow_cnt_d;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
  logic [31:0]       ts_q, ts_d;
`endif

  logic head_vld, pop, qual, mode_ok, full, push, drop;
  rec_t new_rec, head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    occ_d          = occ_q;
    mem_d          = mem_q;
    overflow_d     = overflow_q;
    fetch_cnt_d    = fetch_cnt_q;
    complete_cnt_d = complete_cnt_q;
    overflow_cnt_d = overflow_cnt_q;
    last_rd_d      = bus.instrmem_rd;
    last_pc_d      = bus.PC;

    head_vld = (occ_q != '0);
    pop      = head_vld & bus.out_ready;
    mode_ok  = (CAPTURE_MODE == 0) ? 1'b1 : (!last_rd_q || (bus.PC != last_pc_q));
    qual     = (state_q == S_RUN) & bus.instrmem_rd & mode_ok;
    full     = (occ_q == FULL_OCC);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = qual & (!full | pop);
    drop     = qual & full & !pop;

    new_rec       = '0;
    new_rec.pc    = bus.PC;
    new_rec.instr = bus.instr_dout;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
    new_rec.ts    = ts_q;
    ts_d          = ts_q + 32'd1;
`endif

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) begin
      mem_d[wr_ptr_q] = new_rec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase

    if (qual) fetch_cnt_d = sat_inc(fetch_cnt_q);
    if (drop) begin
      overflow_cnt_d = sat_inc(overflow_cnt_q);
      overflow_d     = 1'b1;
    end
    if ((state_q != S_IDLE) && bus.complete_instr) complete_cnt_d = sat_inc(complete_cnt_q);

    case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_RUN;
      S_RUN:   if (!bus.enable) state_d = head_vld ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (bus.enable)     state_d = S_RUN;
        else if (!head_vld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
      last_rd_q      <= 1'b0;
      last_pc_q      <= '0;
      overflow_q     <= 1'b0;
      fetch_cnt_q    <= '0;
      complete_cnt_q <= '0;
      overflow_cnt_q <= '0;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
      ts_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      last_rd_q      <= last_rd_d;
      last_pc_q      <= last_pc_d;
      overflow_q     <= overflow_d;
      fetch_cnt_q    <= fetch_cnt_d;
      complete_cnt_q <= complete_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
      ts_q           <= ts_d;
`endif
    end
  end

  // Storage needs no reset: the head is gated by occupancy.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid  = head_vld;
  assign bus.out_pc     = head_vld ? head.pc : '0;
  assign bus.out_instr  = head_vld ? head.instr : '0;
  assign bus.out_opcode = head_vld ? head.instr[DATA_W-1:DATA_W-4] : 4'h0;
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
  assign bus.out_ts     = head_vld ? head.ts : 32'h0;
`endif

  assign occupancy    = occ_q;
  assign overflow     = overflow_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign complete_cnt = complete_cnt_q;
  assign overflow_cnt = overflow_cnt_q;
endmodule

// File: tb/tb_inst_fetch_capture.sv
// Bench: mode-0 (16-bit counters) and mode-1 (4-bit counters) instances share stimulus
// and are checked every cycle against a queue-based model, plus literal checks.
module tb_inst_fetch_capture;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset, enable, rd, complete, ready;
  logic [15:0] pc, instr;
  always #5 clock = ~clock;

  inst_fetch_capture_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
  inst_fetch_capture_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  assign bus0.enable = enable;  assign bus1.enable = enable;
  assign bus0.PC = pc;          assign bus1.PC = pc;
  assign bus0.instrmem_rd = rd; assign bus1.instrmem_rd = rd;
  assign bus0.instr_dout = instr; assign bus1.instr_dout = instr;
  assign bus0.complete_instr = complete; assign bus1.complete_instr = complete;
  assign bus0.out_ready = ready; assign bus1.out_ready = ready;

  logic [3:0]  occ0, occ1;
  logic        ovf0, ovf1;
  logic [15:0] fc0, cc0, oc0;
  logic [3:0]  fc1, cc1, oc1;

  inst_fetch_capture #(.DEPTH(DEPTH), .CNT_W(16), .CAPTURE_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .occupancy(occ0), .overflow(ovf0),
    .fetch_cnt(fc0), .complete_cnt(cc0), .overflow_cnt(oc0));
  inst_fetch_capture #(.DEPTH(DEPTH), .CNT_W(4), .CAPTURE_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .occupancy(occ1), .overflow(ovf1),
    .fetch_cnt(fc1), .complete_cnt(cc1), .overflow_cnt(oc1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: record = {ts, pc, instr}; phase 0 idle, 1 run, 2 drain.
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];
  int   ph[2], fcm[2], ccm[2], ocm[2], cmax[2], mode[2];
  bit   ovm[2];
  bit   last_rd, started;
  logic [15:0] last_pc;
  logic [31:0] ts;

  function automatic int q_size(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction
  function automatic logic [63:0] q_head(input int i);
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction
  task automatic q_push(input int i, input logic [63:0] r);
    if (i == 0) mq0.push_back(r); else mq1.push_back(r);
  endtask
  task automatic q_pop(input int i);
    if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  initial begin
    cmax[0] = 65535; cmax[1] = 15;
    mode[0] = 0;     mode[1] = 1;
    started = 1'b0;
  end

  always @(posedge clock) begin : model
    int occ;
    bit pop, qual;
    if (reset) begin
      mq0.delete(); mq1.delete();
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; fcm[i] = 0; ccm[i] = 0; ocm[i] = 0; ovm[i] = 1'b0;
      end
      last_rd = 1'b0; last_pc = '0; ts = '0; started = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        occ  = q_size(i);
        pop  = (occ > 0) && ready;
        qual = (ph[i] == 1) && rd && (mode[i] == 0 || !last_rd || pc != last_pc);
        if (qual && fcm[i] < cmax[i]) fcm[i]++;
        if (pop) q_pop(i);
        if (qual) begin
          if (occ < DEPTH || pop) q_push(i, {ts, pc, instr});
          else begin
            if (ocm[i] < cmax[i]) ocm[i]++;
            ovm[i] = 1'b1;
          end
        end
        if (ph[i] != 0 && complete && ccm[i] < cmax[i]) ccm[i]++;
        if (ph[i] == 0) begin
          if (enable) ph[i] = 1;
        end else if (ph[i] == 1) begin
          if (!enable) ph[i] = (occ != 0) ? 2 : 0;
        end else begin
          if (enable) ph[i] = 1;
          else if (occ == 0) ph[i] = 0;
        end
      end
      last_rd = rd; last_pc = pc; ts = ts + 32'd1;
    end
  end

  task automatic compare(input int i, input logic v, input logic [15:0] opc_pc,
                         input logic [15:0] oins, input logic [3:0] oop, input logic [3:0] occ,
                         input logic ov, input logic [15:0] f, input logic [15:0] c,
                         input logic [15:0] o, input logic [31:0] ots);
    logic [63:0] h;
    h = (q_size(i) > 0) ? q_head(i) : 64'h0;
    chk($sformatf("dut%0d out_valid", i), 64'(v), 64'(q_size(i) > 0));
    chk($sformatf("dut%0d out_pc", i), 64'(opc_pc), 64'(h[31:16]));
    chk($sformatf("dut%0d out_instr", i), 64'(oins), 64'(h[15:0]));
    chk($sformatf("dut%0d out_opcode", i), 64'(oop), 64'(h[15:12]));
    chk($sformatf("dut%0d occupancy", i), 64'(occ), 64'(q_size(i)));
    chk($sformatf("dut%0d overflow", i), 64'(ov), 64'(ovm[i]));
    chk($sformatf("dut%0d fetch_cnt", i), 64'(f), 64'(fcm[i]));
    chk($sformatf("dut%0d complete_cnt", i), 64'(c), 64'(ccm[i]));
    chk($sformatf("dut%0d overflow_cnt", i), 64'(o), 64'(ocm[i]));
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
    chk($sformatf("dut%0d out_ts", i), 64'(ots), 64'(h[63:32]));
`else
    if (ots != 32'h0) chk("unused ts", 64'(ots), 64'h0);
`endif
  endtask

  always @(negedge clock) begin
    logic [31:0] t0, t1;
    if (started) begin
`ifdef INST_FETCH_CAPTURE_TIMESTAMP_EN
      t0 = bus0.out_ts; t1 = bus1.out_ts;
`else
      t0 = 32'h0; t1 = 32'h0;
`endif
      compare(0, bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_opcode, occ0, ovf0,
              fc0, cc0, oc0, t0);
      compare(1, bus1.out_valid, bus1.out_pc, bus1.out_instr, bus1.out_opcode, occ1, ovf1,
              16'(fc1), 16'(cc1), 16'(oc1), t1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; rd = 1'b0; complete = 1'b0; ready = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rd = 1'b0; complete = 1'b0; ready = 1'b0;
    pc = 16'h0; instr = 16'h0;
    do_reset();
    chk("reset out_valid", 64'(bus0.out_valid), 64'h0);
    chk("reset fetch_cnt", 64'(fc0), 64'h0);
    chk("reset occupancy", 64'(occ0), 64'h0);

    // Three consecutive mode-0 fetches stream straight out.
    enable = 1'b1; ready = 1'b1; step(1);
    rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 16'h3000 + 16'(k); instr = 16'(k) << 12 | 16'h0123;
      step(1);
      chk("s1 head valid", 64'(bus0.out_valid), 64'h1);
      chk("s1 head pc", 64'(bus0.out_pc), 64'h3000 + 64'(k));
    end
    rd = 1'b0; step(3);
    chk("s1 fetch_cnt", 64'(fc0), 64'd3);
    chk("s1 drained", 64'(occ0), 64'd0);

    // Mode 1 ignores a held PC.
    do_reset();
    enable = 1'b1; ready = 1'b1; step(1);
    rd = 1'b1; pc = 16'h3000; step(4);
    pc = 16'h3001; step(1);
    rd = 1'b0; step(3);
    chk("s2 mode1 fetch_cnt", 64'(fc1), 64'd2);
    chk("s2 mode0 fetch_cnt", 64'(fc0), 64'd5);

    // Overflow with the consumer stalled, then full+push+pop.
    do_reset();
    enable = 1'b1; ready = 1'b0; step(1);
    rd = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pc = 16'h4000 + 16'(k); instr = 16'hA000 + 16'(k); step(1);
    end
    chk("s3 occupancy", 64'(occ0), 64'd8);
    chk("s3 overflow", 64'(ovf0), 64'd1);
    chk("s3 overflow_cnt", 64'(oc0), 64'd2);
    pc = 16'h5000; ready = 1'b1; step(1);
    chk("s4 occupancy", 64'(occ0), 64'd8);
    chk("s4 overflow_cnt", 64'(oc0), 64'd2);
    rd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("s4 drain order", 64'(bus0.out_pc), (k < 7) ? 64'h4001 + 64'(k) : 64'h5000);
      step(1);
    end
    chk("s4 empty", 64'(occ0), 64'd0);

    // Drop enable with three held entries.
    do_reset();
    enable = 1'b1; ready = 1'b0; step(1);
    rd = 1'b1;
    for (int k = 0; k < 3; k++) begin pc = 16'h6000 + 16'(k); step(1); end
    enable = 1'b0; rd = 1'b0; step(1);
    rd = 1'b1; pc = 16'h6100; step(3);
    chk("s5 no capture", 64'(fc0), 64'd3);
    chk("s5 held", 64'(occ0), 64'd3);
    ready = 1'b1; step(3);
    chk("s5 drained", 64'(occ0), 64'd0);
    step(2);
    chk("s5 idle no capture", 64'(fc0), 64'd3);

    // Reset in the middle of a drain.
    do_reset();
    enable = 1'b1; ready = 1'b0; step(1);
    rd = 1'b1;
    for (int k = 0; k < 3; k++) begin pc = 16'h7000 + 16'(k); step(1); end
    enable = 1'b0; rd = 1'b0; step(1);
    ready = 1'b1; step(1);
    reset = 1'b1; step(1);
    chk("s6 reset valid", 64'(bus0.out_valid), 64'h0);
    chk("s6 reset occupancy", 64'(occ0), 64'h0);
    reset = 1'b0;

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset    = ($urandom_range(0, 599) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      rd       = ($urandom_range(0, 3) != 0);
      pc       = 16'h3000 + 16'($urandom_range(0, 3));
      instr    = 16'($urandom);
      complete = ($urandom_range(0, 2) == 0);
      ready    = ((cyc / 150) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      step(1);
    end
    reset = 1'b0; step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
